// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage with PC, imem req/valid handshake and retire counter
// Ports: clk/rst; PC_sel, PC_target, stall from controller/datapath;
//   imem_req, imem_addr, imem_rdata, imem_valid to instruction memory;
//   instr + decode slices, instr_valid, PC, PC_plus4, instret, misalign_fault to the core.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned next PC traps into FAULT instead of being aligned.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_sel,
  input  logic [31:0] PC_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic        funct7b5,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PC_plus4,
  output logic [31:0] instret,
  output logic        misalign_fault
);
  typedef enum logic [1:0] {BOOT, WAIT, HOLD, FAULT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, instret_q, instret_d, tgt, next_pc;
  logic        iv_q, iv_d, req_q, req_d, fault_q, fault_d, retire, fetch, mis;
  assign PC_plus4 = pc_q + 32'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign tgt = PC_target;
  assign mis = next_pc[1:0] != 2'b00;
`else
  // Low target bits are dropped so the PC stays word aligned without a trap path.
  assign tgt = PC_target & ~32'h3;
  assign mis = 1'b0;
`endif
  assign next_pc = PC_sel ? tgt : PC_plus4;
  assign retire  = state_q == HOLD && !stall;
  assign fetch   = state_q == WAIT && imem_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      iv_q      <= 1'b0;
      instret_q <= 32'd0;
      req_q     <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      iv_q      <= iv_d;
      instret_q <= instret_d;
      req_q     <= req_d;
      fault_q   <= fault_d;
    end
  end
  always_comb begin
    state_d = state_q == BOOT ? WAIT :
              state_q == WAIT ? (imem_valid ? HOLD : WAIT) :
              state_q == HOLD ? (stall ? HOLD : (mis ? FAULT : WAIT)) : state_q;
  end
  // Request and fault flags are computed from the next state so they come straight off flops.
  always_comb begin
    pc_d      = retire ? next_pc : pc_q;
    instret_d = retire ? instret_q + 32'd1 : instret_q;
    instr_d   = fetch ? imem_rdata : retire ? NOP_INSTR : instr_q;
    iv_d      = fetch | (iv_q & ~retire);
    req_d     = state_d == WAIT;
    fault_d   = state_d == FAULT;
  end
  assign imem_req       = req_q;
  assign imem_addr      = pc_q;
  assign PC             = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = iv_q;
  assign instret        = instret_q;
  assign misalign_fault = fault_q;
  assign opcode         = instr_q[6:0];
  assign funct3         = instr_q[14:12];
  assign funct7b5       = instr_q[30];
  assign rd             = instr_q[11:7];
  assign rs1            = instr_q[19:15];
  assign rs2            = instr_q[24:20];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, PC_sel, stall, imem_req, imem_valid, funct7b5, instr_valid, misalign_fault;
  logic [31:0] PC_target, imem_addr, imem_rdata, instr, PC, PC_plus4, instret;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  int total = 0;
  int bad = 0;
  fetch_unit #(.RESET_PC(32'h100), .NOP_INSTR(32'h13)) dut (
    .clk(clk), .rst(rst), .PC_sel(PC_sel), .PC_target(PC_target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .instr(instr), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5), .rd(rd), .rs1(rs1),
    .rs2(rs2), .instr_valid(instr_valid), .PC(PC), .PC_plus4(PC_plus4), .instret(instret),
    .misalign_fault(misalign_fault)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b1; PC_sel = 1'b0; PC_target = 32'h0; stall = 1'b0; imem_valid = 1'b0; imem_rdata = 32'h0;
    tick(); tick();
    chk("rst_pc", PC, 32'h100);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_instr", instr, 32'h13);
    chk("rst_iv", {31'd0, instr_valid}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_fault", {31'd0, misalign_fault}, 32'd0);
    rst = 1'b0;
    tick();
    chk("boot_req", {31'd0, imem_req}, 32'd1);
    chk("boot_addr", imem_addr, 32'h100);
    imem_valid = 1'b1; imem_rdata = 32'h00500093; stall = 1'b1;
    tick();
    imem_valid = 1'b0;
    chk("f1_iv", {31'd0, instr_valid}, 32'd1);
    chk("f1_instr", instr, 32'h00500093);
    chk("f1_opcode", {25'd0, opcode}, 32'h13);
    chk("f1_funct3", {29'd0, funct3}, 32'd0);
    chk("f1_rd", {27'd0, rd}, 32'd1);
    chk("f1_rs1", {27'd0, rs1}, 32'd0);
    chk("f1_rs2", {27'd0, rs2}, 32'd5);
    chk("f1_f7b5", {31'd0, funct7b5}, 32'd0);
    chk("f1_req", {31'd0, imem_req}, 32'd0);
    chk("f1_pc4", PC_plus4, 32'h104);
    imem_valid = 1'b1; imem_rdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_instr", instr, 32'h00500093);
      chk("stall_pc", PC, 32'h100);
      chk("stall_instret", instret, 32'd0);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_iv", {31'd0, instr_valid}, 32'd1);
    end
    imem_valid = 1'b0; stall = 1'b0;
    tick();
    chk("ret1_pc", PC, 32'h104);
    chk("ret1_instret", instret, 32'd1);
    chk("ret1_iv", {31'd0, instr_valid}, 32'd0);
    chk("ret1_instr", instr, 32'h13);
    chk("ret1_req", {31'd0, imem_req}, 32'd1);
    tick();
    chk("wait_req", {31'd0, imem_req}, 32'd1);
    chk("wait_instret", instret, 32'd1);
    imem_valid = 1'b1; imem_rdata = 32'h40000033; PC_sel = 1'b1; PC_target = 32'h200;
    tick();
    imem_valid = 1'b0;
    chk("f2_f7b5", {31'd0, funct7b5}, 32'd1);
    chk("f2_opcode", {25'd0, opcode}, 32'h33);
    tick();
    PC_sel = 1'b0;
    chk("br_addr", imem_addr, 32'h200);
    chk("br_instret", instret, 32'd2);
    imem_valid = 1'b1; imem_rdata = 32'h13; PC_sel = 1'b1; PC_target = 32'hFFFF_FFFC;
    tick(); tick();
    chk("hi_addr", imem_addr, 32'hFFFF_FFFC);
    PC_sel = 1'b0;
    tick();
    chk("hi_pc4", PC_plus4, 32'h0);
    tick();
    chk("wrap_pc", PC, 32'h0);
    chk("wrap_instret", instret, 32'd4);
    imem_rdata = 32'h12345678; rst = 1'b1;
    tick();
    rst = 1'b0; imem_valid = 1'b0;
    chk("rw_pc", PC, 32'h100);
    chk("rw_instret", instret, 32'd0);
    chk("rw_req", {31'd0, imem_req}, 32'd0);
    chk("rw_iv", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("rw2_instr", instr, 32'h13);
    chk("rw2_iv", {31'd0, instr_valid}, 32'd0);
    chk("rw2_req", {31'd0, imem_req}, 32'd1);
    imem_valid = 1'b1; imem_rdata = 32'h13; PC_sel = 1'b1; PC_target = 32'h202;
    tick(); tick();
    PC_sel = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      chk("mis_fault", {31'd0, misalign_fault}, 32'd1);
      chk("mis_req", {31'd0, imem_req}, 32'd0);
      chk("mis_iv", {31'd0, instr_valid}, 32'd0);
      chk("mis_instret", instret, 32'd1);
      chk("mis_pc", PC, 32'h202);
      tick();
    end
    rst = 1'b1; imem_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("mis_rst", {31'd0, misalign_fault}, 32'd0);
`else
    chk("mis_addr", imem_addr, 32'h200);
    chk("mis_fault", {31'd0, misalign_fault}, 32'd0);
    chk("mis_req", {31'd0, imem_req}, 32'd1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
